// File: rtl/diamond_square_gen.sv
// diamond_square_gen: diamond-square heightmap generator with a column-major streamed readout.
// Define DS_SATURATE_EN to clamp overflowing samples to full scale; by default they wrap.
module diamond_square_gen #(
    parameter int DIM_POWER = 3,
    parameter int Z_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [Z_WIDTH-1:0] corner_tl,
    input  logic [Z_WIDTH-1:0] corner_tr,
    input  logic [Z_WIDTH-1:0] corner_bl,
    input  logic [Z_WIDTH-1:0] corner_br,
    input  logic [15:0]        seed,
    input  logic               rough_en,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic [Z_WIDTH-1:0] z,
    output logic               out_last,
    output logic               done
);
    localparam int DIM = (1 << DIM_POWER) + 1;
    localparam int N = DIM * DIM;
    localparam int AW = $clog2(N);
    localparam logic [9:0] LAST = 10'(DIM - 1);

    typedef enum logic [2:0] {IDLE, INIT, DIAMOND, SQUARE, READOUT} state_t;
    state_t state_q, state_d;
    logic [9:0] c_q, c_d, r_q, r_d, step_q, step_d;
    logic [2:0] ph_q, ph_d;
    logic [Z_WIDTH+1:0] acc_q, acc_d, sum;
    logic [15:0] lfsr_q, lfsr_d;
    logic rough_q, rough_d, valid_q, valid_d, done_q, done_d;
    logic [Z_WIDTH-1:0] z_q, z_d, rnd, pt;
    logic [Z_WIDTH-1:0] crn_q [4];
    logic [Z_WIDTH-1:0] crn_d [4];
    logic [Z_WIDTH-1:0] mem [N];
    logic [Z_WIDTH-1:0] rd_data, wr_data;
    logic [AW-1:0] rd_addr, wr_addr;
    logic we;
    logic [9:0] half, nc, nx, ny;
    int sh, sv;
`ifdef DS_SATURATE_EN
    logic [Z_WIDTH:0] tot;
`endif

    function automatic logic [9:0] wrap(input int i);
        return 10'(i < 0 ? i + DIM - 1 : (i > DIM - 1 ? i - (DIM - 1) : i));
    endfunction

    function automatic logic [AW-1:0] addr(input logic [9:0] cx, input logic [9:0] ry);
        return AW'(int'(cx) * DIM + int'(ry));
    endfunction

    // Neighbour k = ph: bit0 picks the +/- side, bit1 picks the row axis (square) or row side (diamond).
    always_comb begin
        half = step_q >> 1;
        nc = c_q + step_q;
        sh = ph_q[0] ? int'(half) : -int'(half);
        sv = ph_q[1] ? int'(half) : -int'(half);
        nx = wrap(state_q == SQUARE && ph_q[1] ? int'(c_q) : int'(c_q) + sh);
        ny = wrap(state_q == SQUARE ? (ph_q[1] ? int'(r_q) + sh : int'(r_q)) : int'(r_q) + sv);
        rd_addr = state_q == READOUT ? addr(c_q, r_q) : addr(nx, ny);
        sum = acc_q + (Z_WIDTH+2)'(rd_data);
        rnd = rough_q ? (lfsr_q[Z_WIDTH-1:0] & Z_WIDTH'(step_q - 10'd1)) : '0;
`ifdef DS_SATURATE_EN
        tot = {1'b0, sum[Z_WIDTH+1:2]} + {1'b0, rnd};
        pt = tot[Z_WIDTH] ? '1 : tot[Z_WIDTH-1:0];
`else
        pt = sum[Z_WIDTH+1:2] + rnd;
`endif
    end

    always_comb begin
        state_d = state_q;
        c_d = c_q;
        r_d = r_q;
        step_d = step_q;
        ph_d = ph_q;
        acc_d = acc_q;
        lfsr_d = lfsr_q;
        rough_d = rough_q;
        valid_d = valid_q;
        done_d = 1'b0;
        z_d = z_q;
        crn_d = crn_q;
        we = 1'b0;
        wr_addr = addr(c_q, r_q);
        wr_data = pt;
        case (state_q)
            IDLE: if (start) begin
                state_d = INIT;
                ph_d = 3'd0;
                crn_d = '{corner_tl, corner_tr, corner_bl, corner_br};
                lfsr_d = seed == 16'd0 ? 16'h0001 : seed;
                rough_d = rough_en;
            end
            INIT: begin
                we = 1'b1;
                wr_addr = addr(ph_q[0] ? LAST : 10'd0, ph_q[1] ? LAST : 10'd0);
                wr_data = crn_q[ph_q[1:0]];
                ph_d = ph_q + 3'd1;
                if (ph_q == 3'd3) begin
                    state_d = DIAMOND;
                    ph_d = 3'd0;
                    step_d = LAST;
                    c_d = LAST >> 1;
                    r_d = LAST >> 1;
                end
            end
            DIAMOND, SQUARE: begin
                ph_d = ph_q + 3'd1;
                acc_d = ph_q == 3'd0 ? '0 : sum;
                if (ph_q == 3'd4) begin
                    we = 1'b1;
                    ph_d = 3'd0;
                    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    if (nc <= LAST) c_d = nc;
                    else if (state_q == DIAMOND) begin
                        c_d = half;
                        r_d = r_q + step_q <= LAST ? r_q + step_q : 10'd0;
                        state_d = r_q + step_q <= LAST ? DIAMOND : SQUARE;
                    end else if (r_q + half <= LAST) begin
                        r_d = r_q + half;
                        c_d = ((r_q + half) & half) != 10'd0 ? 10'd0 : half;
                    end else if (step_q == 10'd2) begin
                        state_d = READOUT;
                        c_d = 10'd0;
                        r_d = 10'd0;
                    end else begin
                        state_d = DIAMOND;
                        step_d = half;
                        c_d = half >> 1;
                        r_d = half >> 1;
                    end
                end
            end
            READOUT: begin
                // ph0 issues the read, ph1 captures it, ph2 waits for the handshake
                if (ph_q == 3'd0) ph_d = 3'd1;
                else if (ph_q == 3'd1) begin
                    z_d = rd_data;
                    valid_d = 1'b1;
                    ph_d = 3'd2;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    ph_d = 3'd0;
                    if (c_q == LAST && r_q == LAST) begin
                        state_d = IDLE;
                        done_d = 1'b1;
                        c_d = 10'd0;
                        r_d = 10'd0;
                    end else begin
                        r_d = r_q == LAST ? 10'd0 : r_q + 10'd1;
                        c_d = r_q == LAST ? c_q + 10'd1 : c_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q <= '0;
            r_q <= '0;
            step_q <= '0;
            ph_q <= '0;
            acc_q <= '0;
            lfsr_q <= 16'h0001;
            rough_q <= 1'b0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            z_q <= '0;
        end else begin
            state_q <= state_d;
            c_q <= c_d;
            r_q <= r_d;
            step_q <= step_d;
            ph_q <= ph_d;
            acc_q <= acc_d;
            lfsr_q <= lfsr_d;
            rough_q <= rough_d;
            valid_q <= valid_d;
            done_q <= done_d;
            z_q <= z_d;
        end
    end

    always_ff @(posedge clk) begin
        crn_q <= crn_d;
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    assign busy = state_q != IDLE;
    assign out_valid = valid_q;
    assign x = c_q;
    assign y = r_q;
    assign z = z_q;
    assign out_last = valid_q && c_q == LAST && r_q == LAST;
    assign done = done_q;
endmodule

// File: doc/diamond_square_gen.md
DIAMOND_SQUARE_GEN -- requirements
Module: diamond_square_gen

Interface
REQ-001 SHALL have parameter DIM_POWER, default 3, grid side DIM = 2^DIM_POWER + 1, legal range 1..8.
REQ-002 SHALL have parameter Z_WIDTH, default 8, height sample width, legal range 4..16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin generation; sampled only in IDLE.
REQ-006 corner_tl, corner_tr, corner_bl, corner_br  in  Z_WIDTH each  corner seeds, latched on accepted start; tl=(x0,y0), tr=(xDIM-1,y0), bl=(x0,yDIM-1), br=(xDIM-1,yDIM-1).
REQ-007 seed  in  16  LFSR seed, latched on accepted start.
REQ-008 rough_en  in  1  latched on accepted start; 0 forces random term to zero.
REQ-009 busy  out  1  high from the cycle after start is accepted until return to IDLE.
REQ-010 out_valid  out  1; out_ready  in  1  readout handshake.
REQ-011 x, y  out  10 each; z  out  Z_WIDTH; out_last  out  1  readout sample, coordinates, last-sample flag.
REQ-012 done  out  1  one-cycle pulse on return to IDLE after the last handshake.

Function
REQ-013 States SHALL be IDLE, INIT, DIAMOND, SQUARE, READOUT; IDLE->INIT on start; INIT->DIAMOND after four corner writes; DIAMOND->SQUARE->DIAMOND per level, step halving; SQUARE->READOUT after the step=2 level; READOUT->IDLE on the out_last handshake.
REQ-014 Storage SHALL be DIM*DIM words of Z_WIDTH, one read and one write port, one-cycle read latency; all points rewritten every run.
REQ-015 Diamond point (c,r) SHALL be the average of its four diagonal neighbours at distance half=step/2: (sum of 4) >> 2, sum width Z_WIDTH+2.
REQ-016 Square point SHALL average its four orthogonal neighbours at distance half; an index i<0 maps to i+DIM-1 and i>DIM-1 maps to i-(DIM-1) (toroidal wrap).
REQ-017 Random term SHALL be lfsr[Z_WIDTH-1:0] & ((1<<log2(step))-1) when rough_en=1, else 0; the LFSR is 16-bit Fibonacci, taps 16,14,13,11, loaded from seed (0 replaced by 16'h0001), advanced exactly once per computed point.
REQ-018 Written value SHALL be average + random term, with overflow handled per REQ-025.
REQ-019 READOUT SHALL stream column-major (x outer, y inner) from (0,0) to (DIM-1,DIM-1); out_last=1 only on (DIM-1,DIM-1).
REQ-020 out_valid, x, y, z, out_last SHALL hold stable while out_valid=1 and out_ready=0; next sample presented no earlier than the cycle after a handshake; out_ready ignored when out_valid=0.
REQ-021 start while busy=1 SHALL be ignored; start in the cycle done pulses SHALL be accepted.

Reset
REQ-022 reset SHALL force IDLE and drive busy=0, out_valid=0, out_last=0, done=0, x=0, y=0, z=0, LFSR=16'h0001.
REQ-023 reset mid-generation or mid-readout SHALL abort in that cycle with no further handshake; memory contents afterwards undefined.
REQ-024 reset overrides start when both are high.

Configuration
REQ-025 Macro DS_SATURATE_EN defined: average+random exceeding 2^Z_WIDTH-1 SHALL clamp to 2^Z_WIDTH-1; undefined: result SHALL wrap modulo 2^Z_WIDTH.

Verification
REQ-026 DIM_POWER=1, rough_en=0, all corners 100 -> nine samples all z=100, out_last on (2,2), done pulse.
REQ-027 DIM_POWER=1, rough_en=0, corners 0,0,0, br=200 -> center (1,1) z=50; (1,0) z=25 via wrap.
REQ-028 DIM_POWER=1, rough_en=1, Z_WIDTH=8, all corners 255, seed 16'h0001: with DS_SATURATE_EN all z=255; without, every point whose random term was 1 reads 0.
REQ-029 DIM_POWER=3, out_ready toggling 1-of-3 cycles -> exactly 81 handshakes, column-major order, outputs stable across stalls.
REQ-030 reset asserted mid-SQUARE at DIM_POWER=3 -> next cycle busy=0, out_valid=0; following start produces a full 81-sample run identical to an unreset run with the same inputs.
REQ-031 start pulsed while busy -> ignored; same seed and corners twice -> bit-identical streams.
